// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
//   Sequences an 8-sprite + 1-background 2bpp shift-register block for one
//   scanline: latches sprite attributes, fetches background tiles over a
//   req/ack handshake, drives load/shift strobes and resolves the output pixel.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   line_start, pixel_en  line begin pulse, per-active-pixel strobe
//   attr_we/idx/x/vis     shadow sprite attribute write
//   bg_req, bg_ack        background tile fetch handshake
//   sr_out, sr_enable     shift-register block data in / shift enables out
//   load_sprite, load_bg  register load strobes
//   pix_valid/color/src   resolved pixel (1-cycle latency)
//   bg_underrun           sticky: tile reloaded before its fetch was acked

// Per-sprite window test and opacity for the current pixel.
module sprite_lane #(
    parameter int XW    = 10,
    parameter int SPR_W = 16
) (
    input  logic          vis,
    input  logic [XW-1:0] x,
    input  logic [XW-1:0] hpos,
    input  logic          fire,
    input  logic [1:0]    pix,
    output logic          en,
    output logic          opaque
);
    // One extra bit so x + SPR_W never wraps; sprites past the line end clip.
    logic [XW:0] lo, hi, h;

    assign lo     = {1'b0, x};
    assign hi     = lo + (XW+1)'(SPR_W);
    assign h      = {1'b0, hpos};
    assign en     = fire & vis & (h >= lo) & (h < hi);
    assign opaque = en & (pix != 2'b00);
endmodule

module sprite_line_scheduler #(
    parameter int NUM_SPR  = 8,
    parameter int SPR_W    = 16,
    parameter int H_ACTIVE = 640,
    parameter int XW       = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    line_start,
    input  logic                    pixel_en,
    input  logic                    attr_we,
    input  logic [2:0]              attr_idx,
    input  logic [XW-1:0]           attr_x,
    input  logic                    attr_vis,
    output logic                    bg_req,
    input  logic                    bg_ack,
    input  logic [NUM_SPR:0][1:0]   sr_out,
    output logic [NUM_SPR:0]        sr_enable,
    output logic                    load_sprite,
    output logic                    load_bg,
    output logic                    pix_valid,
    output logic [1:0]              pix_color,
    output logic [3:0]              pix_src,
    output logic                    bg_underrun
);
    localparam int            SW          = $clog2(SPR_W);
    localparam logic [XW-1:0] HPOS_LAST   = XW'(H_ACTIVE - 1);
    // Reload position that fetches the final tile of the line.
    localparam logic [XW-1:0] HPOS_LAST_RL = XW'(H_ACTIVE - SPR_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, ACTIVE} state_t;

    typedef struct packed {
        logic          vis;
        logic [XW-1:0] x;
    } spr_attr_t;

    state_t                    state;
    logic [XW-1:0]             hpos;
    logic                      ack_seen;   // tile data acked since the last bg load
    spr_attr_t [NUM_SPR-1:0]   shadow_attr;
    spr_attr_t [NUM_SPR-1:0]   active_attr;

    logic                      fire;
    logic                      reload;
    logic                      ack_now;
    logic [NUM_SPR-1:0]        spr_en;
    logic [NUM_SPR-1:0]        spr_opaque;
    logic [3:0]                win_src;
    logic [1:0]                win_color;

    assign fire    = (state == ACTIVE) && pixel_en;
    assign reload  = fire && (hpos[SW-1:0] == SW'(SPR_W - 1)) && (hpos != HPOS_LAST);
    assign ack_now = bg_req && bg_ack;

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_lane
        sprite_lane #(.XW(XW), .SPR_W(SPR_W)) u_lane (
            .vis    (active_attr[g].vis),
            .x      (active_attr[g].x),
            .hpos   (hpos),
            .fire   (fire),
            .pix    (sr_out[g]),
            .en     (spr_en[g]),
            .opaque (spr_opaque[g])
        );
    end

    // Background shifts every pixel except the one where it is reloaded.
    assign sr_enable   = {fire && !reload, spr_en};
    assign load_sprite = (state == LOAD);
    assign load_bg     = (state == LOAD) || reload;

    // Lowest-index opaque sprite wins, else background.
    always_comb begin
        win_src   = 4'(NUM_SPR);
        win_color = sr_out[NUM_SPR];
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (spr_opaque[i]) begin
                win_src   = 4'(i);
                win_color = sr_out[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hpos        <= '0;
            bg_req      <= 1'b0;
            ack_seen    <= 1'b0;
            bg_underrun <= 1'b0;
            shadow_attr <= '0;
            active_attr <= '0;
            pix_valid   <= 1'b0;
            pix_color   <= 2'b00;
            pix_src     <= 4'd0;
        end else begin
            if (attr_we)
                shadow_attr[attr_idx] <= '{vis: attr_vis, x: attr_x};
            // Copies the pre-write shadow, so a same-cycle write lands next line.
            if (line_start)
                active_attr <= shadow_attr;

            pix_valid <= fire;
            if (fire) begin
                pix_src   <= win_src;
                pix_color <= win_color;
            end

            if (line_start) begin
                // Start or abort: any outstanding ack is forgotten.
                state    <= FETCH;
                bg_req   <= 1'b1;
                ack_seen <= 1'b0;
            end else begin
                case (state)
                    IDLE: bg_req <= 1'b0;
                    FETCH: begin
                        if (bg_ack) begin
                            bg_req <= 1'b0;
                            state  <= LOAD;
                        end
                    end
                    LOAD: begin
                        hpos     <= '0;
                        ack_seen <= 1'b0;
                        bg_req   <= 1'(H_ACTIVE > SPR_W);
                        state    <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (ack_now) begin
                            bg_req   <= 1'b0;
                            ack_seen <= 1'b1;
                        end
                        // An ack arriving on the reload cycle still counts as in time.
                        if (reload) begin
                            if (!ack_seen && !ack_now)
                                bg_underrun <= 1'b1;
                            ack_seen <= 1'b0;
                            bg_req   <= (hpos < HPOS_LAST_RL);
                        end
                        if (pixel_en) begin
                            if (hpos == HPOS_LAST) begin
                                hpos   <= '0;
                                bg_req <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                hpos <= hpos + XW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
